// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral endpoint, oversampled on the system clock.
// Ports: clk, rst_n (async, active-low); serial pins sclk, cs, mosi -> miso;
//   TX load port tx_data/tx_valid/tx_ready; RX word rx_data with rx_valid
//   strobe; status busy, frame_err and tx_underrun strobes.
module spi_slave #(
    parameter int SPI_TRF_BIT = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [SPI_TRF_BIT-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SPI_TRF_BIT-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   tx_underrun
);
    localparam int W  = SPI_TRF_BIT;
    localparam int CW = $clog2(SPI_TRF_BIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Two synchroniser flops plus one history flop for edge detection.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [W-1:0]   tx_sh_q, tx_sh_d;
    logic [W-1:0]   rx_sh_q, rx_sh_d;
    logic [W-1:0]   buf_q, buf_d;
    logic           full_q, full_d;
    logic           miso_q, miso_d;
    logic [W-1:0]   rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           underrun_q, underrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            buf_q       <= '0;
            full_q      <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        buf_d       = buf_q;
        full_d      = full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        underrun_d  = 1'b0;

        // A load while empty wins even against a same-cycle frame start,
        // so the word is kept for the following frame.
        if (tx_valid && !full_q) begin
            buf_d  = tx_data;
            full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    if (full_q) begin
                        tx_sh_d = buf_q;
                        full_d  = 1'b0;
                    end else begin
                        tx_sh_d    = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    if (idx_q < CW'(W)) begin
                        miso_d  = tx_sh_q[W-1];
                        tx_sh_d = tx_sh_q << 1;
                        idx_d   = idx_q + CW'(1);
                    end else begin
                        miso_d = 1'b0;
                    end
                end else if (sclk_fall) begin
                    rx_sh_d = (rx_sh_q << 1) | {{(W-1){1'b0}}, mosi_q[1]};
                    cnt_d   = cnt_q + CW'(1);
                    // Last bit: publish the word on the same edge that
                    // shifts it in.
                    if (cnt_q == CW'(W - 1)) begin
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign miso        = miso_q;
    assign tx_ready    = ~full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != IDLE);
    assign frame_err   = frame_err_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with a bit-banged SPI master.
// Checks duplex data, underrun, abort, back-to-back, reset and extra clocks.
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [11:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic        tx_underrun;

    spi_slave #(.SPI_TRF_BIT(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_rv = 0;
    int n_fe = 0;
    int n_un = 0;
    int b_rv, b_fe, b_un;
    logic [11:0] miso_cap;
    logic        extra_or;
    logic        rdy_at_start;

    always @(negedge clk) begin
        if (rx_valid) n_rv++;
        if (frame_err) n_fe++;
        if (tx_underrun) n_un++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rv = n_rv;
        b_fe = n_fe;
        b_un = n_un;
    endtask

    task automatic load(input logic [11:0] v);
        @(negedge clk);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master: mosi and sclk rise together, miso sampled just before the fall.
    task automatic frame(input logic [11:0] w, input int ncyc,
                         input int abort_at);
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        rdy_at_start = tx_ready;
        miso_cap = '0;
        extra_or = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (i == abort_at) break;
            mosi = (i < 12) ? w[11-i] : 1'b0;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            if (i < 12) miso_cap = {miso_cap[10:0], miso};
            else extra_or = extra_or | miso;
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        cs = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_miso"}, 32'(miso), 32'd0);
        chk({pfx, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({pfx, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({pfx, "_underrun"}, 32'(tx_underrun), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full duplex
        load(12'h3C6);
        chk("dup_ready_low", 32'(tx_ready), 32'd0);
        snap();
        frame(12'hA5C, 13, -1);
        chk("dup_ready_start", 32'(rdy_at_start), 32'd1);
        chk("dup_miso", 32'(miso_cap), 32'h3C6);
        chk("dup_rx", 32'(rx_data), 32'hA5C);
        chk("dup_rv_cnt", 32'(n_rv - b_rv), 32'd1);
        chk("dup_fe_cnt", 32'(n_fe - b_fe), 32'd0);
        chk("dup_un_cnt", 32'(n_un - b_un), 32'd0);
        chk("dup_busy", 32'(busy), 32'd0);

        // Underrun
        snap();
        frame(12'h001, 13, -1);
        chk("un_cnt", 32'(n_un - b_un), 32'd1);
        chk("un_miso", 32'(miso_cap), 32'h000);
        chk("un_rx", 32'(rx_data), 32'h001);

        // Abort after 5 bits
        snap();
        frame(12'hFFF, 13, 5);
        chk("ab_fe_cnt", 32'(n_fe - b_fe), 32'd1);
        chk("ab_rv_cnt", 32'(n_rv - b_rv), 32'd0);
        chk("ab_rx", 32'(rx_data), 32'h001);
        chk("ab_busy", 32'(busy), 32'd0);

        // Back-to-back, second word loaded mid-frame
        load(12'h111);
        fork
            frame(12'h0F0, 13, -1);
            begin
                repeat (60) @(negedge clk);
                load(12'h222);
            end
        join
        chk("b2b_ready1", 32'(rdy_at_start), 32'd1);
        chk("b2b_miso1", 32'(miso_cap), 32'h111);
        chk("b2b_rx1", 32'(rx_data), 32'h0F0);
        chk("b2b_ready_full", 32'(tx_ready), 32'd0);
        frame(12'h70E, 13, -1);
        chk("b2b_ready2", 32'(rdy_at_start), 32'd1);
        chk("b2b_miso2", 32'(miso_cap), 32'h222);
        chk("b2b_rx2", 32'(rx_data), 32'h70E);

        // Reset mid-frame after bit 6
        load(12'h7E7);
        snap();
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid");
        cs = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame(12'h5A5, 13, -1);
        chk("mid_rx", 32'(rx_data), 32'h5A5);
        chk("mid_rv_cnt", 32'(n_rv - b_rv), 32'd1);
        chk("mid_fe_cnt", 32'(n_fe - b_fe), 32'd0);

        // Extra sclk cycles
        load(12'h6B1);
        snap();
        frame(12'h3A7, 14, -1);
        chk("ext_miso", 32'(miso_cap), 32'h6B1);
        chk("ext_rx", 32'(rx_data), 32'h3A7);
        chk("ext_rv_cnt", 32'(n_rv - b_rv), 32'd1);
        chk("ext_miso_done", 32'(extra_or), 32'd0);
        chk("ext_fe_cnt", 32'(n_fe - b_fe), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
